mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller between the EX/MEM latch and the MEM/WB latch.
//  Turns a load/store request into a held dcache handshake (dmemREN/dmemWEN until dhit).
//  Holds the load data, stalls upstream latches while the access is outstanding and
//  produces the MEM/WB write enable. Also keeps a watchdog and a stall-cycle counter.
// PARAMETERS
//  TIMEOUT   256  BUSY cycles without dhit before timeout_err sets (>=2)
//  CNT_W     32   width of stall_cycles counter
// PORTS
//  CLK           in   1      rising-edge clock
//  RST           in   1      reset; synchronous, active-high
//  dREN_in       in   1      EX/MEM: instruction is a load
//  dWEN_in       in   1      EX/MEM: instruction is a store
//  addr_in       in   32     EX/MEM: aluResult, byte address
//  store_in      in   32     EX/MEM: store data
//  pipe_adv      in   1      1 = no other stall source; pipeline may advance this cycle
//  dhit          in   1      dcache: access complete this cycle
//  dmemload      in   32     dcache: load data, valid with dhit
//  dmemREN       out  1      dcache read request
//  dmemWEN       out  1      dcache write request
//  dmemaddr      out  32     dcache address (registered)
//  dmemstore     out  32     dcache store data (registered)
//  dMemLoad      out  32     load data to MEM/WB dMemLoad_in
//  mem_stall     out  1      1 = freeze PC, IF/ID, ID/EX, EX/MEM latches
//  mem_wb_wen    out  1      MEM/WB latch wen
//  timeout_err   out  1      sticky watchdog flag
//  stall_cycles  out  CNT_W  saturating count of cycles with mem_stall=1
// BEHAVIOUR
//  Reset (RST=1 at edge): state=IDLE; all outputs, request regs, counters = 0.
//   RST mid-access drops dmemREN/dmemWEN at that edge. A late dhit is ignored.
//  States: IDLE, BUSY, HOLD.
//  Terms:
//   req  = dREN_in|dWEN_in; a store takes priority if both are set (dWEN_in=dREN_in=1 -> write).
//   done = (BUSY&dhit&pipe_adv) | (HOLD&pipe_adv).
//  IDLE:
//   - req=1: latch addr_in/store_in/type into request regs; -> BUSY.
//   - req=0: stay IDLE; instruction passes with no added cycle.
//  BUSY:
//   - dmemREN or dmemWEN = 1 per the latched type; dmemaddr/dmemstore come from the regs.
//   - dhit=1: capture dmemload into the dMemLoad register (load only). The capture is
//     visible on dMemLoad the same cycle via bypass. Then:
//       pipe_adv=1 -> IDLE;  pipe_adv=0 -> HOLD.
//   - dhit=0: stay BUSY.
//  HOLD:
//   - dmemREN=dmemWEN=0; dMemLoad is held.
//   - pipe_adv=1 -> IDLE; else stay HOLD.
//  mem_stall = ((IDLE&req) | BUSY | HOLD) & ~done.
//  mem_wb_wen = pipe_adv & ~mem_stall.
//  Minimum memory-op latency: 2 cycles (accept, then BUSY with dhit). A non-memory op takes 1.
//  Back-to-back memory ops: the done cycle advances EX/MEM. The next op is accepted in the
//   following IDLE cycle. No request is ever issued from IDLE.
//  Store: the request stays asserted until dhit, and is never reissued after dhit.
//  Watchdog: counter clears on entering BUSY and counts each BUSY cycle without dhit.
//   Reaching TIMEOUT-1 sets timeout_err (sticky until RST). The FSM stays BUSY.
//  stall_cycles += 1 on each cycle with mem_stall=1; saturates at all-ones.
//  Bubble (req=0) while pipe_adv=0: mem_wb_wen=0, FSM idle.
// STRUCTURE
//  Shared package cpu_types_pkg gets:
//   - typedef enum logic [1:0] {IDLE, BUSY, HOLD} memctrl_state_t;
//   - typedef word_t (32 bit).
//  One sub-module: sat_counter #(W) for stall_cycles. Reuse it for the watchdog if convenient.
// TESTING
//  1 Load 0x40, dhit on first BUSY cycle, pipe_adv=1, dmemload=0xDEADBEEF
//    -> mem_stall=1 for 1 cycle; dMemLoad=0xDEADBEEF and mem_wb_wen=1 in cycle 2.
//  2 Store 0x80 data 0x12345678, dhit after 3 BUSY cycles -> dmemWEN=1 for exactly 3 cycles,
//    dmemaddr=0x80, dmemstore=0x12345678 stable throughout, stall_cycles=3.
//  3 Load hits while pipe_adv=0 for 2 cycles -> HOLD; dmemREN=0, dMemLoad stable,
//    mem_wb_wen=1 only on the cycle pipe_adv returns.
//  4 RST=1 in BUSY -> next cycle dmemREN=0, mem_stall=0, state IDLE, counters 0;
//    a dhit then has no effect.
//  5 TIMEOUT=4, no dhit -> timeout_err=1 after the 3rd BUSY cycle, dmemREN still 1.
//  6 dREN_in=dWEN_in=1 -> write issued (dmemWEN=1, dmemREN=0);
//    non-memory op -> mem_stall=0, mem_wb_wen=pipe_adv.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types used by the MEM-stage access controller
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} memctrl_state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: EX/MEM request, dcache handshake and MEM/WB control bundle
interface mem_access_ctrl_if;
    import cpu_types_pkg::*;
    logic  dREN_in, dWEN_in, pipe_adv, dhit;
    logic  dmemREN, dmemWEN, mem_stall, mem_wb_wen;
    word_t addr_in, store_in, dmemload;
    word_t dmemaddr, dmemstore, dMemLoad;
    modport master (
        input  dREN_in, dWEN_in, addr_in, store_in, pipe_adv, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dMemLoad, mem_stall, mem_wb_wen
    );
    modport slave (
        output dREN_in, dWEN_in, addr_in, store_in, pipe_adv, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dMemLoad, mem_stall, mem_wb_wen
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with sync clear that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    // count up on inc, hold once every bit is set
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage dcache handshake, load capture, stall and MEM/WB write enable
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic                CLK,
    input  logic                RST,
    mem_access_ctrl_if.master   bus,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    stall_cycles
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    memctrl_state_t  state;
    word_t           addr_r, store_r, load_r;
    logic            req, done, hit_load;
    logic [WD_W-1:0] wd_cnt;
    assign bus.dmemaddr  = addr_r;
    assign bus.dmemstore = store_r;
    // stall/advance decode; a load hit is forwarded straight to MEM/WB in its hit cycle
    always_comb begin
        req            = bus.dREN_in | bus.dWEN_in;
        done           = (state == BUSY && bus.dhit && bus.pipe_adv) || (state == HOLD && bus.pipe_adv);
        bus.mem_stall  = ((state == IDLE && req) || state == BUSY || state == HOLD) && !done;
        bus.mem_wb_wen = bus.pipe_adv && !bus.mem_stall;
        hit_load       = state == BUSY && bus.dhit && bus.dmemREN;
        bus.dMemLoad   = hit_load ? bus.dmemload : load_r;
    end
    // request FSM; dmemREN/dmemWEN double as the latched access type while BUSY
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bus.dmemREN <= 1'b0;
            bus.dmemWEN <= 1'b0;
            addr_r      <= '0;
            store_r     <= '0;
            load_r      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_r      <= bus.addr_in;
                    store_r     <= bus.store_in;
                    bus.dmemWEN <= bus.dWEN_in;
                    bus.dmemREN <= !bus.dWEN_in;
                    state       <= BUSY;
                end
                BUSY: if (bus.dhit) begin
                    if (bus.dmemREN) load_r <= bus.dmemload;
                    bus.dmemREN <= 1'b0;
                    bus.dmemWEN <= 1'b0;
                    state       <= bus.pipe_adv ? IDLE : HOLD;
                end else if (wd_cnt == WD_W'(TIMEOUT - 2)) begin
                    timeout_err <= 1'b1;
                end
                HOLD: if (bus.pipe_adv) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (1'b0),
        .inc (bus.mem_stall),
        .cnt (stall_cycles)
    );
    sat_counter #(.W(WD_W)) u_watchdog (
        .clk (CLK),
        .rst (RST),
        .clr (state == IDLE && req),
        .inc (state == BUSY && !bus.dhit),
        .cnt (wd_cnt)
    );
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed-vector bench for the MEM-stage access controller
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        timeout_err;
    logic [31:0] stall_cycles;
    int          n_vec = 0;
    int          n_err = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .CLK          (clk),
        .RST          (rst),
        .bus          (bus),
        .timeout_err  (timeout_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.dREN_in = 0; bus.dWEN_in = 0; bus.addr_in = 0; bus.store_in = 0;
        bus.pipe_adv = 0; bus.dhit = 0; bus.dmemload = 0;
        cyc(); cyc();
        rst = 0;
        #1;
        chk("rst_ren",    32'(bus.dmemREN), 0);
        chk("rst_wen",    32'(bus.dmemWEN), 0);
        chk("rst_stall",  32'(bus.mem_stall), 0);
        chk("rst_cnt",    stall_cycles, 0);
        chk("rst_to",     32'(timeout_err), 0);
        chk("rst_load",   bus.dMemLoad, 0);
        chk("rst_addr",   bus.dmemaddr, 0);
        chk("bubble_wen", 32'(bus.mem_wb_wen), 0);
        // non-memory op passes in one cycle
        cyc(); bus.pipe_adv = 1; #1;
        chk("nomem_stall", 32'(bus.mem_stall), 0);
        chk("nomem_wbwen", 32'(bus.mem_wb_wen), 1);
        // load hit on first BUSY cycle
        cyc(); bus.dREN_in = 1; bus.addr_in = 32'h40; #1;
        chk("ld_acc_stall", 32'(bus.mem_stall), 1);
        chk("ld_acc_wbwen", 32'(bus.mem_wb_wen), 0);
        chk("ld_acc_ren",   32'(bus.dmemREN), 0);
        cyc(); bus.dhit = 1; bus.dmemload = 32'hDEADBEEF; #1;
        chk("ld_busy_ren",  32'(bus.dmemREN), 1);
        chk("ld_addr",      bus.dmemaddr, 32'h40);
        chk("ld_hit_stall", 32'(bus.mem_stall), 0);
        chk("ld_hit_wbwen", 32'(bus.mem_wb_wen), 1);
        chk("ld_bypass",    bus.dMemLoad, 32'hDEADBEEF);
        cyc(); bus.dREN_in = 0; bus.dhit = 0; bus.dmemload = 0; #1;
        chk("ld_after_ren", 32'(bus.dmemREN), 0);
        chk("ld_held",      bus.dMemLoad, 32'hDEADBEEF);
        chk("ld_cnt",       stall_cycles, 1);
        cyc(); rst = 1;
        cyc(); rst = 0; #1;
        chk("rst2_cnt",  stall_cycles, 0);
        chk("rst2_load", bus.dMemLoad, 0);
        // store, dhit on third BUSY cycle
        cyc(); bus.dWEN_in = 1; bus.addr_in = 32'h80; bus.store_in = 32'h12345678; #1;
        chk("st_acc_stall", 32'(bus.mem_stall), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.dhit = (i == 2); bus.addr_in = 32'hFFFFFFFC; bus.store_in = 0; #1;
            chk("st_wen",   32'(bus.dmemWEN), 1);
            chk("st_ren",   32'(bus.dmemREN), 0);
            chk("st_addr",  bus.dmemaddr, 32'h80);
            chk("st_data",  bus.dmemstore, 32'h12345678);
            chk("st_stall", 32'(bus.mem_stall), (i == 2) ? 0 : 1);
        end
        cyc(); bus.dWEN_in = 0; bus.dhit = 0; #1;
        chk("st_done_wen", 32'(bus.dmemWEN), 0);
        chk("st_cnt",      stall_cycles, 3);
        chk("st_to",       32'(timeout_err), 0);
        // load hit while pipeline frozen -> HOLD
        cyc(); bus.dREN_in = 1; bus.addr_in = 32'h44; #1;
        chk("hd_acc_stall", 32'(bus.mem_stall), 1);
        cyc(); bus.dhit = 1; bus.dmemload = 32'hCAFEF00D; bus.pipe_adv = 0; #1;
        chk("hd_bypass",  bus.dMemLoad, 32'hCAFEF00D);
        chk("hd_hitstall", 32'(bus.mem_stall), 1);
        chk("hd_hitwbwen", 32'(bus.mem_wb_wen), 0);
        cyc(); bus.dhit = 0; bus.dmemload = 32'h11111111; #1;
        chk("hd_ren",   32'(bus.dmemREN), 0);
        chk("hd_load",  bus.dMemLoad, 32'hCAFEF00D);
        chk("hd_wbwen", 32'(bus.mem_wb_wen), 0);
        chk("hd_stall", 32'(bus.mem_stall), 1);
        cyc(); bus.pipe_adv = 1; #1;
        chk("hd_rel_wbwen", 32'(bus.mem_wb_wen), 1);
        chk("hd_rel_stall", 32'(bus.mem_stall), 0);
        chk("hd_rel_load",  bus.dMemLoad, 32'hCAFEF00D);
        cyc(); bus.dREN_in = 0; #1;
        chk("hd_idle_stall", 32'(bus.mem_stall), 0);
        chk("hd_cnt",        stall_cycles, 6);
        // reset in the middle of BUSY
        cyc(); bus.dREN_in = 1; bus.addr_in = 32'h48; #1;
        cyc(); #1;
        chk("rb_busy_ren", 32'(bus.dmemREN), 1);
        rst = 1;
        cyc(); rst = 0; bus.dREN_in = 0; bus.dhit = 1; bus.dmemload = 32'h55; #1;
        chk("rb_ren",   32'(bus.dmemREN), 0);
        chk("rb_stall", 32'(bus.mem_stall), 0);
        chk("rb_cnt",   stall_cycles, 0);
        chk("rb_load",  bus.dMemLoad, 0);
        cyc(); bus.dhit = 0; #1;
        chk("rb_late_load", bus.dMemLoad, 0);
        chk("rb_late_ren",  32'(bus.dmemREN), 0);
        // load and store together -> write wins
        cyc(); bus.dREN_in = 1; bus.dWEN_in = 1; bus.addr_in = 32'h90; bus.store_in = 32'hA5A5A5A5; #1;
        chk("both_acc_stall", 32'(bus.mem_stall), 1);
        cyc(); #1;
        chk("both_wen",  32'(bus.dmemWEN), 1);
        chk("both_ren",  32'(bus.dmemREN), 0);
        chk("both_data", bus.dmemstore, 32'hA5A5A5A5);
        cyc(); bus.dhit = 1; #1;
        chk("both_done", 32'(bus.mem_wb_wen), 1);
        cyc(); bus.dREN_in = 0; bus.dWEN_in = 0; bus.dhit = 0; #1;
        // watchdog with TIMEOUT=4
        cyc(); bus.dREN_in = 1; bus.addr_in = 32'h100; #1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("wd_pre", 32'(timeout_err), 0);
        end
        cyc(); #1;
        chk("wd_err",   32'(timeout_err), 1);
        chk("wd_ren",   32'(bus.dmemREN), 1);
        chk("wd_stall", 32'(bus.mem_stall), 1);
        cyc(); bus.dhit = 1; #1;
        cyc(); bus.dREN_in = 0; bus.dhit = 0; #1;
        chk("wd_sticky", 32'(timeout_err), 1);
        rst = 1;
        cyc(); rst = 0; #1;
        chk("wd_rst", 32'(timeout_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
